simon_sound: RTL

SIMON_SOUND -- requirements
Module: simon_sound

---
 rtl/simon_pkg.sv | 12 +
 rtl/simon_sound_tone_gen.sv | 30 +++
 rtl/simon_sound.sv | 126 ++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared FSM state encoding and jingle note tables
package simon_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAMP, S_BUZZ, S_JINGLE} state_t;
  // each table packs four 2-bit lamp-tone indices, note 0 in the low bits
  localparam logic [7:0] WIN_SEQ = 8'b11_10_01_00;
  localparam logic [7:0] HS_SEQ  = 8'b10_11_10_11;
  function automatic logic [1:0] jingle_note(input logic hs, input logic [1:0] idx);
    logic [7:0] seq;
    seq = hs ? HS_SEQ : WIN_SEQ;
    return seq[{idx, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/simon_sound_tone_gen.sv
// tone_gen: square-wave divider that flips WAVE every HALF clocks
module tone_gen #(
  parameter int DIV_W = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] HALF,
  input  logic             RESTART,
  input  logic             EN,
  output logic             WAVE
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic wave_q, wave_d, hit;
  // count to HALF-1 then flip; a restart or disable snaps both back to 0
  always_comb begin
    hit = cnt_q == HALF - DIV_W'(1);
    cnt_d = (!EN || RESTART || hit) ? '0 : cnt_q + DIV_W'(1);
    wave_d = (!EN || RESTART) ? 1'b0 : wave_q ^ hit;
  end
  // divider and wave registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wave_q <= wave_d;
    end
  assign WAVE = wave_q;
endmodule

// File: rtl/simon_sound.sv
// simon_sound: lamp tones, lose buzz and win/high-score jingles for the Simon game
module simon_sound import simon_pkg::*; #(
  parameter int          DIV_W    = 20,
  parameter int          DUR_W    = 27,
  parameter int unsigned HALF0    = 60241,
  parameter int unsigned HALF1    = 80645,
  parameter int unsigned HALF2    = 99206,
  parameter int unsigned HALF3    = 119617,
  parameter int unsigned HALFB    = 595238,
  parameter int unsigned NOTE_LEN = 7500000,
  parameter int unsigned BUZZ_LEN = 75000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       WIN,
  input  logic       LOSE,
  input  logic       HS,
  output logic       SPKR,
  output logic       BUSY
);
  state_t state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0] note_q, note_d, lamp_q;
  logic seq_hs_q, seq_hs_d, busy_q, busy_d;
  logic win_q, lose_q, hs_q, arm_q;
  logic lose_rise, hs_rise, win_rise, restart, tone_en;
  logic [DIV_W-1:0] half;

  function automatic logic [DIV_W-1:0] tone_half(input logic [1:0] sel);
    return sel == 2'd0 ? DIV_W'(HALF0) : sel == 2'd1 ? DIV_W'(HALF1) :
           sel == 2'd2 ? DIV_W'(HALF2) : DIV_W'(HALF3);
  endfunction

  // prioritised event handling, duration/note sequencing and tone selection
  always_comb begin
    lose_rise = LOSE & ~lose_q & arm_q;
    hs_rise = HS & ~hs_q & arm_q;
    win_rise = WIN & ~win_q & arm_q;
    state_d = state_q;
    dur_d = dur_q;
    note_d = note_q;
    seq_hs_d = seq_hs_q;
    restart = 1'b0;
    if (lose_rise) begin
      state_d = S_BUZZ;
      dur_d = '0;
      restart = 1'b1;
    end else if (hs_rise && state_q != S_BUZZ) begin
      state_d = S_JINGLE;
      seq_hs_d = 1'b1;
      note_d = 2'd0;
      dur_d = '0;
      restart = 1'b1;
    end else if (win_rise && (state_q == S_IDLE || state_q == S_LAMP)) begin
      state_d = S_JINGLE;
      seq_hs_d = 1'b0;
      note_d = 2'd0;
      dur_d = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = LAMP_ENA ? S_LAMP : S_IDLE;
          restart = LAMP_ENA;
        end
        S_LAMP: begin
          state_d = LAMP_ENA ? S_LAMP : S_IDLE;
          restart = LAMP_ENA && LAMP != lamp_q;
        end
        S_BUZZ: begin
          state_d = dur_q == DUR_W'(BUZZ_LEN - 1) ? S_IDLE : S_BUZZ;
          dur_d = dur_q == DUR_W'(BUZZ_LEN - 1) ? '0 : dur_q + DUR_W'(1);
        end
        default: begin
          restart = dur_q == DUR_W'(NOTE_LEN - 1);
          dur_d = restart ? '0 : dur_q + DUR_W'(1);
          note_d = restart ? note_q + 2'd1 : note_q;
          state_d = restart && note_q == 2'd3 ? S_IDLE : S_JINGLE;
        end
      endcase
    end
    tone_en = state_d != S_IDLE;
    half = state_d == S_BUZZ ? DIV_W'(HALFB) :
           state_d == S_JINGLE ? tone_half(jingle_note(seq_hs_d, note_d)) : tone_half(LAMP);
    busy_d = state_d == S_BUZZ || state_d == S_JINGLE;
  end

  // state, sequencing counters, edge-detect copies and the post-reset arm flag
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      dur_q <= '0;
      note_q <= 2'd0;
      seq_hs_q <= 1'b0;
      busy_q <= 1'b0;
      lamp_q <= 2'd0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
      hs_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q <= dur_d;
      note_q <= note_d;
      seq_hs_q <= seq_hs_d;
      busy_q <= busy_d;
      lamp_q <= LAMP;
      win_q <= WIN;
      lose_q <= LOSE;
      hs_q <= HS;
      arm_q <= 1'b1;
    end

  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .CLK(CLK),
    .RST(RST),
    .HALF(half),
    .RESTART(restart),
    .EN(tone_en),
    .WAVE(SPKR)
  );

  assign BUSY = busy_q;
endmodule
